audio_lpf_decimate: RTL

Decimating FIR low-pass filter that sits directly downstream of the FM demodulator. It pops demodulated 16-bit signed samples from the demodulator's output FIFO and filters them with a fixed 32-tap audio low-pass. It produces one output sample per DECIM input samples and pushes each result into a downstream FIFO. A single time-multiplexed multiply-accumulate unit performs one tap per clock.

---
 rtl/audio_lpf_decimate_pkg.sv | 27 ++
 rtl/audio_lpf_decimate_if.sv | 22 ++
 rtl/audio_lpf_decimate_fir_mac.sv | 33 +++
 rtl/audio_lpf_decimate.sv | 119 +++++++++++
 4 files changed

// File: rtl/audio_lpf_decimate_pkg.sv
// Shared constants, coefficient table and FSM state type for the decimating audio low-pass.
// Coefficients are Q10, symmetric, with DC gain 1040/1024.
package audio_lpf_pkg;

    localparam int DEF_DATA_SIZE = 16;
    localparam int DEF_TAPS      = 32;
    localparam int DEF_DECIM     = 8;
    localparam int DEF_FRAC_BITS = 10;
    localparam int DEF_ACC_WIDTH = 40;

    typedef logic signed [DEF_DATA_SIZE-1:0] coeff_t;

    localparam coeff_t AUDIO_LPF_COEFFS [DEF_TAPS] = '{
        -16'sd2,  -16'sd3,  -16'sd4,  -16'sd4,  -16'sd2,  16'sd2,   16'sd8,   16'sd16,
         16'sd26,  16'sd38,  16'sd50,  16'sd62,  16'sd72,  16'sd80,  16'sd86,  16'sd95,
         16'sd95,  16'sd86,  16'sd80,  16'sd72,  16'sd62,  16'sd50,  16'sd38,  16'sd26,
         16'sd16,  16'sd8,   16'sd2,  -16'sd2,  -16'sd4,  -16'sd4,  -16'sd3,  -16'sd2
    };

    typedef enum logic [1:0] {
        S_READ,
        S_MAC,
        S_SCALE,
        S_WRITE
    } state_t;

endpackage

// File: rtl/audio_lpf_decimate_if.sv
// FIFO-side signals of the filter: FWFT read port upstream, write port downstream.
// The master modport is the filter itself.
interface audio_lpf_decimate_if #(
    parameter int DATA_SIZE = audio_lpf_pkg::DEF_DATA_SIZE
);
    logic signed [DATA_SIZE-1:0] x_in;
    logic                        x_empty;
    logic                        x_rd_en;
    logic signed [DATA_SIZE-1:0] y_out;
    logic                        y_wr_en;
    logic                        y_full;

    modport master (
        input  x_in, x_empty, y_full,
        output x_rd_en, y_out, y_wr_en
    );

    modport slave (
        output x_in, x_empty, y_full,
        input  x_rd_en, y_out, y_wr_en
    );
endinterface

// File: rtl/audio_lpf_decimate_fir_mac.sv
// Registered multiply-accumulate: one full-width signed product per enabled cycle.
// Clear wins over enable.
module fir_mac #(
    parameter int DATA_SIZE = audio_lpf_pkg::DEF_DATA_SIZE,
    parameter int ACC_WIDTH = audio_lpf_pkg::DEF_ACC_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_clr,
    input  logic                        i_en,
    input  logic signed [DATA_SIZE-1:0] i_coeff,
    input  logic signed [DATA_SIZE-1:0] i_sample,
    output logic signed [ACC_WIDTH-1:0] o_acc
);
    logic signed [2*DATA_SIZE-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   r_acc;

    assign w_prod     = i_coeff * i_sample;
    assign w_prod_ext = {{(ACC_WIDTH-2*DATA_SIZE){w_prod[2*DATA_SIZE-1]}}, w_prod};
    assign o_acc      = r_acc;

    // NOTE: non-blocking assignment keeps every register update on the same edge semantics.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end
endmodule

// File: rtl/audio_lpf_decimate.sv
// Decimating 32-tap FIR low-pass: collect DECIM samples, run one MAC per tap,
// scale/saturate, then write one result downstream.
module audio_lpf_decimate
    import audio_lpf_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int TAPS      = DEF_TAPS,
    parameter int DECIM     = DEF_DECIM,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    audio_lpf_decimate_if.master  bus
);
    localparam int TAP_W = (TAPS  > 1) ? $clog2(TAPS)  : 1;
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef logic signed [DATA_SIZE-1:0] sample_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [TAP_W-1:0]   r_tap;
    sample_t            r_delay [TAPS];
    sample_t            r_y;

    logic                          w_pop;
    logic                          w_last;
    logic                          w_write;
    logic                          w_mac_en;
    logic signed [ACC_WIDTH-1:0]   w_acc;
    logic signed [ACC_WIDTH-1:0]   w_shifted;
    logic [ACC_WIDTH-DATA_SIZE:0]  w_hi;
    sample_t                       w_sat;

    // Reset gates the pop so the FIFO is never drained while the block is held in reset.
    assign w_pop    = !i_rst && (r_state == S_READ) && !bus.x_empty;
    assign w_last   = w_pop && (r_cnt == CNT_W'(DECIM-1));
    assign w_write  = (r_state == S_WRITE) && !bus.y_full;
    assign w_mac_en = (r_state == S_MAC);

    assign bus.x_rd_en = w_pop;
    assign bus.y_wr_en = w_write;
    assign bus.y_out   = r_y;

    fir_mac #(
        .DATA_SIZE (DATA_SIZE),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_last),
        .i_en     (w_mac_en),
        .i_coeff  (AUDIO_LPF_COEFFS[r_tap]),
        .i_sample (r_delay[r_tap]),
        .o_acc    (w_acc)
    );

    // Floor shift, then clamp whenever the bits above the output sign are not all equal.
    assign w_shifted = w_acc >>> FRAC_BITS;
    assign w_hi      = w_shifted[ACC_WIDTH-1:DATA_SIZE-1];

    // NOTE: default assignment first, so no path through this block leaves w_sat unassigned (no latch).
    always_comb begin
        w_sat = w_shifted[DATA_SIZE-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            w_sat = w_hi[ACC_WIDTH-DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                              : {1'b0, {(DATA_SIZE-1){1'b1}}};
        end
    end

    // NOTE: the delay line is reset so the first outputs after reset never see stale samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < TAPS; i++) r_delay[i] <= '0;
        end else if (w_pop) begin
            r_delay[0] <= bus.x_in;
            for (int i = 1; i < TAPS; i++) r_delay[i] <= r_delay[i-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_READ;
            r_cnt   <= '0;
            r_tap   <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                S_READ: begin
                    if (w_pop) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_tap   <= '0;
                            r_state <= S_MAC;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    if (r_tap == TAP_W'(TAPS-1)) begin
                        r_state <= S_SCALE;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_SCALE: begin
                    r_y     <= w_sat;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (!bus.y_full) r_state <= S_READ;
                end
                default: r_state <= S_READ;
            endcase
        end
    end
endmodule
